// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: F1 start-light sequencer and reaction timer.
// Lights five LED pairs one step apart and holds them for a random time taken
// from the LFSR. After lights-out it times the driver's button press in
// milliseconds and flags jump starts. All timing advances on tick_ms.
// Optional feature macro BEST_TIME_EN: keeps the best (minimum) reaction time
// in best_ms. Without it, best_ms is tied to MAX_MS.
module f1_reaction_ctrl #(
   parameter int STEP_MS       = 500,
   parameter int MIN_DELAY_MS  = 500,
   parameter int DELAY_STEP_MS = 50,
   parameter int MAX_MS        = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_ms,
   input  logic        trigger,
   input  logic        react,
   input  logic [5:0]  prbs,
   output logic        en_lfsr,
   output logic [9:0]  ledr,
   output logic [13:0] reaction_ms,
   output logic        result_valid,
   output logic        false_start,
   output logic        busy,
   output logic [13:0] best_ms
);

   localparam logic [13:0] STEP_LAST = 14'(STEP_MS - 1);
   localparam logic [13:0] MIN_D     = 14'(MIN_DELAY_MS);
   localparam logic [13:0] DSTEP     = 14'(DELAY_STEP_MS);
   localparam logic [13:0] MAX_C     = 14'(MAX_MS);
   localparam logic [13:0] MAX_LAST  = 14'(MAX_MS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LIGHTS, S_HOLD, S_GO, S_DONE, S_FOUL
   } state_t;

   state_t      state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic [2:0]  stage_q, stage_d;
   logic [13:0] hold_q, hold_d;
   logic [9:0]  ledr_q, ledr_d;
   logic [13:0] reaction_q, reaction_d;
   logic        valid_q, valid_d;
   logic        false_q, false_d;
   logic        busy_q, busy_d;
   logic        en_lfsr_q, en_lfsr_d;
   logic        trig_q, react_q;
   logic        trig_rise, react_rise;
   logic [3:0]  shamt;

   assign trig_rise  = trigger & ~trig_q;
   assign react_rise = react & ~react_q;
   // Next pair to light sits two bits lower for each stage already lit.
   assign shamt      = 4'd8 - {stage_q, 1'b0};

   // State and datapath registers, cleared asynchronously so lights go dark at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         stage_q    <= '0;
         hold_q     <= '0;
         ledr_q     <= '0;
         reaction_q <= '0;
         valid_q    <= 1'b0;
         false_q    <= 1'b0;
         busy_q     <= 1'b0;
         en_lfsr_q  <= 1'b1;
         trig_q     <= 1'b0;
         react_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stage_q    <= stage_d;
         hold_q     <= hold_d;
         ledr_q     <= ledr_d;
         reaction_q <= reaction_d;
         valid_q    <= valid_d;
         false_q    <= false_d;
         busy_q     <= busy_d;
         en_lfsr_q  <= en_lfsr_d;
         trig_q     <= trigger;
         react_q    <= react;
      end
   end

   // Sequencer: next state, counters, lights and result.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      hold_d     = hold_q;
      ledr_d     = ledr_q;
      reaction_d = reaction_q;
      valid_d    = 1'b0;
      false_d    = false_q;
      case (state_q)
         S_IDLE, S_DONE, S_FOUL: begin
            // A button press in the same cycle as the trigger is ignored.
            if (trig_rise) begin
               state_d = S_LIGHTS;
               stage_d = '0;
               cnt_d   = '0;
               ledr_d  = '0;
               false_d = 1'b0;
            end
         end
         S_LIGHTS: begin
            if (react_rise) begin
               state_d = S_FOUL;
               ledr_d  = 10'b1010101010;
               false_d = 1'b1;
            end else if (tick_ms) begin
               if (cnt_q == STEP_LAST) begin
                  cnt_d   = '0;
                  stage_d = stage_q + 3'd1;
                  ledr_d  = ledr_q | (10'b11 << shamt);
                  if (stage_q == 3'd4) begin
                     hold_d  = MIN_D + {8'd0, prbs} * DSTEP;
                     state_d = S_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 14'd1;
               end
            end
         end
         S_HOLD: begin
            if (react_rise) begin
               state_d = S_FOUL;
               ledr_d  = 10'b1010101010;
               false_d = 1'b1;
            end else if (tick_ms) begin
               if (cnt_q == hold_q - 14'd1) begin
                  ledr_d  = '0;
                  cnt_d   = '0;
                  state_d = S_GO;
               end else begin
                  cnt_d = cnt_q + 14'd1;
               end
            end
         end
         S_GO: begin
            // Press is stamped with the count before this cycle's increment.
            if (react_rise) begin
               state_d    = S_DONE;
               reaction_d = cnt_q;
               valid_d    = 1'b1;
            end else if (tick_ms) begin
               if (cnt_q >= MAX_LAST) begin
                  cnt_d      = MAX_C;
                  state_d    = S_DONE;
                  reaction_d = MAX_C;
                  valid_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 14'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d    = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_GO);
      en_lfsr_d = !((state_d == S_HOLD) || (state_d == S_GO));
   end

`ifdef BEST_TIME_EN
   logic [13:0] best_q;

   // Keep the fastest reaction seen since reset; timeouts never beat it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_q <= MAX_C;
      end else if (valid_q && (reaction_q < best_q)) begin
         best_q <= reaction_q;
      end
   end

   assign best_ms = best_q;
`else
   assign best_ms = MAX_C;
`endif

   assign en_lfsr      = en_lfsr_q;
   assign ledr         = ledr_q;
   assign reaction_ms  = reaction_q;
   assign result_valid = valid_q;
   assign false_start  = false_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// Testbench for f1_reaction_ctrl with small timing parameters and a 1 ms tick
// on every clock. A timeline model (ticks elapsed since the accepted trigger)
// predicts every output; directed literal checks pin key values.
module tb_f1_reaction_ctrl;
   localparam int STEP  = 4;
   localparam int MIN   = 10;
   localparam int DSTEP = 2;
   localparam int MAXV  = 100;
   localparam int L     = 5 * STEP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_ms = 1'b1;
   logic        trigger = 1'b0;
   logic        react = 1'b0;
   logic [5:0]  prbs = 6'd3;
   logic        en_lfsr;
   logic [9:0]  ledr;
   logic [13:0] reaction_ms;
   logic        result_valid;
   logic        false_start;
   logic        busy;
   logic [13:0] best_ms;

   int vectors = 0;
   int errors  = 0;

   f1_reaction_ctrl #(
      .STEP_MS(STEP), .MIN_DELAY_MS(MIN), .DELAY_STEP_MS(DSTEP), .MAX_MS(MAXV)
   ) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .trigger(trigger), .react(react),
      .prbs(prbs), .en_lfsr(en_lfsr), .ledr(ledr), .reaction_ms(reaction_ms),
      .result_valid(result_valid), .false_start(false_start), .busy(busy),
      .best_ms(best_ms)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   bit m_run, m_foul, m_valid, m_pt, m_pr, m_tr, m_rr;
   int m_el, m_hold, m_react, m_best;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_foul = 0; m_valid = 0; m_pt = 0; m_pr = 0;
         m_el = 0; m_hold = 0; m_react = 0; m_best = MAXV;
      end else begin
         m_tr = trigger && !m_pt;
         m_rr = react && !m_pr;
         m_pt = trigger;
         m_pr = react;
`ifdef BEST_TIME_EN
         if (m_valid && m_react < m_best) m_best = m_react;
`endif
         m_valid = 0;
         if (!m_run) begin
            if (m_tr) begin
               m_run = 1; m_el = 0; m_hold = 0; m_foul = 0;
            end
         end else if (m_rr) begin
            m_run = 0;
            if (m_el < L || m_el < L + m_hold) m_foul = 1;
            else begin
               m_react = m_el - (L + m_hold);
               m_valid = 1;
            end
         end else if (tick_ms) begin
            m_el++;
            if (m_el == L) m_hold = MIN + int'(prbs) * DSTEP;
            else if (m_el > L && m_el == L + m_hold + MAXV) begin
               m_run = 0; m_react = MAXV; m_valid = 1;
            end
         end
      end
   end

   function automatic int exp_ledr();
      int v = 0;
      if (m_run) begin
         if (m_el < L) begin
            for (int i = 0; i < m_el / STEP; i++) v |= 3 << (8 - 2 * i);
         end else if (m_el < L + m_hold) v = 'h3FF;
      end else if (m_foul) v = 'h2AA;
      return v;
   endfunction

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("ledr", int'(ledr), exp_ledr());
         check("busy", int'(busy), int'(m_run));
         check("en_lfsr", int'(en_lfsr), int'(!(m_run && m_el >= L)));
         check("false_start", int'(false_start), int'(m_foul));
         check("reaction_ms", int'(reaction_ms), m_react);
         check("result_valid", int'(result_valid), int'(m_valid));
         check("best_ms", int'(best_ms), m_best);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_trigger(input bit with_react);
      @(negedge clk);
      trigger = 1'b1;
      react   = with_react;
      @(negedge clk);
      trigger = 1'b0;
      react   = 1'b0;
   endtask

   int best_after_37;

   initial begin
`ifdef BEST_TIME_EN
      best_after_37 = 37;
`else
      best_after_37 = MAXV;
`endif
      wait_n(3);
      rst = 1'b0;
      wait_n(2);
      // reset state
      check("rst_ledr", int'(ledr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_en_lfsr", int'(en_lfsr), 1);
      check("rst_reaction", int'(reaction_ms), 0);
      check("rst_best", int'(best_ms), MAXV);

      // light sequence with prbs=3 -> hold 16
      prbs = 6'd3;
      pulse_trigger(1'b0);
      check("run_busy", int'(busy), 1);
      check("model_busy", int'(m_run), 1);
      wait_n(4);
      check("stage1", int'(ledr), 'h300);
      wait_n(4);
      check("stage2", int'(ledr), 'h3C0);
      wait_n(12);
      check("stage5", int'(ledr), 'h3FF);
      check("hold_en_lfsr", int'(en_lfsr), 0);
      check("model_hold", m_hold, 16);
      wait_n(15);
      check("hold_end_lit", int'(ledr), 'h3FF);
      wait_n(1);
      check("lights_out", int'(ledr), 0);
      check("go_en_lfsr", int'(en_lfsr), 0);

      // react 37 ticks after lights-out
      wait_n(37);
      react = 1'b1;
      wait_n(1);
      check("react37", int'(reaction_ms), 37);
      check("react37_valid", int'(result_valid), 1);
      check("model_react37", m_react, 37);
      react = 1'b0;
      wait_n(1);
      check("valid_pulse_end", int'(result_valid), 0);
      wait_n(1);
      check("best37", int'(best_ms), best_after_37);

      // second run, prbs=0 -> hold exactly MIN, reaction 50
      prbs = 6'd0;
      pulse_trigger(1'b0);
      wait_n(L + MIN);
      check("prbs0_lights_out", int'(ledr), 0);
      wait_n(50);
      react = 1'b1;
      wait_n(1);
      react = 1'b0;
      check("react50", int'(reaction_ms), 50);
      wait_n(2);
      check("best_kept", int'(best_ms), best_after_37);

      // jump start during hold
      prbs = 6'd5;
      pulse_trigger(1'b0);
      wait_n(L + 5);
      react = 1'b1;
      wait_n(1);
      react = 1'b0;
      check("foul_ledr", int'(ledr), 'h2AA);
      check("foul_flag", int'(false_start), 1);
      check("foul_no_valid", int'(result_valid), 0);
      check("foul_reaction_kept", int'(reaction_ms), 50);
      wait_n(3);
      check("foul_held", int'(false_start), 1);

      // trigger clears foul (simultaneous react ignored), then timeout with prbs=1
      prbs = 6'd1;
      pulse_trigger(1'b1);
      check("foul_cleared", int'(false_start), 0);
      check("restart_busy", int'(busy), 1);
      wait_n(L + MIN + 2);
      check("to_lights_out", int'(ledr), 0);
      trigger = 1'b1;
      wait_n(1);
      trigger = 1'b0;
      wait_n(98);
      check("to_still_busy", int'(busy), 1);
      wait_n(1);
      check("timeout_reaction", int'(reaction_ms), MAXV);
      check("timeout_valid", int'(result_valid), 1);
      check("timeout_idle", int'(busy), 0);
      wait_n(2);
      check("timeout_best", int'(best_ms), best_after_37);

      // asynchronous reset mid-lights
      prbs = 6'd2;
      pulse_trigger(1'b0);
      wait_n(9);
      check("pre_rst_ledr", int'(ledr), 'h3C0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ledr", int'(ledr), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_best", int'(best_ms), MAXV);
      check("async_rst_reaction", int'(reaction_ms), 0);
      wait_n(2);
      rst = 1'b0;
      wait_n(2);
      pulse_trigger(1'b0);
      wait_n(4);
      check("post_rst_stage1", int'(ledr), 'h300);
      wait_n(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
